// File: rtl/mru_tracker.sv
// Most-recently-used key tracker: entry 0 is the newest key, entry NUM-1 the oldest.
// One access per cycle; lookup, hit/miss/evict response and reordering land on the same edge.
module mru_tracker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NUM   = 4,
  parameter int unsigned IDX_W = $clog2(NUM),
  parameter int unsigned CNT_W = $clog2(NUM + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid,
  input  logic                 in_update,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 flush_in,
  output logic [NUM*WIDTH-1:0] out,
  output logic [NUM-1:0]       out_valid,
  output logic [CNT_W-1:0]     count_out,
  output logic                 resp_valid_out,
  output logic                 hit_out,
  output logic [IDX_W-1:0]     hit_idx_out,
  output logic                 evict_valid_out,
  output logic [WIDTH-1:0]     evict_data_out
);

  logic [WIDTH-1:0] ent_q [NUM];
  logic [WIDTH-1:0] ent_d [NUM];
  logic [NUM-1:0]   valid_d;
  logic [CNT_W-1:0] count_d;
  logic             resp_d;
  logic             hit_d;
  logic [IDX_W-1:0] idx_d;
  logic             evict_d;
  logic [WIDTH-1:0] evict_data_d;

  logic             hit_c;
  logic [IDX_W-1:0] hit_idx_c;

  for (genvar g = 0; g < NUM; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = ent_q[g];
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (out_valid[i] && (ent_q[i] == data_in)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ent_d        = ent_q;
    valid_d      = out_valid;
    count_d      = count_out;
    resp_d       = 1'b0;
    hit_d        = 1'b0;
    idx_d        = '0;
    evict_d      = 1'b0;
    evict_data_d = '0;
    if (flush_in) begin
      valid_d = '0;
      count_d = '0;
    end else if (in_valid) begin
      resp_d = 1'b1;
      hit_d  = hit_c;
      idx_d  = hit_c ? hit_idx_c : '0;
      if (in_update) begin
        // A hit only rotates entries 0..k; a miss shifts the whole list.
        for (int i = 1; i < NUM; i++) begin
          if (!hit_c || (IDX_W'(i) <= hit_idx_c)) ent_d[i] = ent_q[i-1];
        end
        ent_d[0] = data_in;
        if (!hit_c) begin
          valid_d = {out_valid[NUM-2:0], 1'b1};
          if (count_out != CNT_W'(NUM)) count_d = count_out + CNT_W'(1);
          evict_d = out_valid[NUM-1];
          if (out_valid[NUM-1]) evict_data_d = ent_q[NUM-1];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM; i++) ent_q[i] <= '0;
      out_valid       <= '0;
      count_out       <= '0;
      resp_valid_out  <= 1'b0;
      hit_out         <= 1'b0;
      hit_idx_out     <= '0;
      evict_valid_out <= 1'b0;
      evict_data_out  <= '0;
    end else begin
      ent_q           <= ent_d;
      out_valid       <= valid_d;
      count_out       <= count_d;
      resp_valid_out  <= resp_d;
      hit_out         <= hit_d;
      hit_idx_out     <= idx_d;
      evict_valid_out <= evict_d;
      evict_data_out  <= evict_data_d;
    end
  end

endmodule

// File: tb/tb_mru_tracker.sv
// Scoreboard bench for mru_tracker (NUM=4, WIDTH=8): stimulus pushes expected
// responses, a negedge monitor pops and compares each DUT response.
module tb_mru_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_update = 1'b0;
  logic [7:0]  data_in = '0;
  logic        flush_in = 1'b0;
  logic [31:0] out;
  logic [3:0]  out_valid;
  logic [2:0]  count_out;
  logic        resp_valid_out;
  logic        hit_out;
  logic [1:0]  hit_idx_out;
  logic        evict_valid_out;
  logic [7:0]  evict_data_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        hit;
    logic [1:0]  idx;
    logic        ev;
    logic [7:0]  evd;
    logic [31:0] o;
    logic [3:0]  v;
    logic [2:0]  c;
  } exp_t;

  exp_t sb_q[$];

  mru_tracker #(.WIDTH(8), .NUM(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_update(in_update),
    .data_in(data_in), .flush_in(flush_in), .out(out), .out_valid(out_valid),
    .count_out(count_out), .resp_valid_out(resp_valid_out), .hit_out(hit_out),
    .hit_idx_out(hit_idx_out), .evict_valid_out(evict_valid_out),
    .evict_data_out(evict_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic exp_t mk(input logic h, input logic [1:0] ix, input logic ev,
                              input logic [7:0] evd, input logic [31:0] o,
                              input logic [3:0] v, input logic [2:0] c);
    exp_t e;
    e.hit = h; e.idx = ix; e.ev = ev; e.evd = evd; e.o = o; e.v = v; e.c = c;
    return e;
  endfunction

  // Call just after a rising edge; the access is sampled on the next one.
  task automatic acc(input logic [7:0] key, input logic upd, input exp_t e);
    in_valid  = 1'b1;
    in_update = upd;
    data_in   = key;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    in_valid  = 1'b0;
    in_update = 1'b0;
  endtask

  // Monitor: compare each response against the oldest pending expectation.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (resp_valid_out) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid_out), 32'h0);
        end else begin
          exp_t e;
          logic [31:0] m;
          e = sb_q.pop_front();
          m = '0;
          for (int i = 0; i < 4; i++) if (e.v[i]) m[i*8 +: 8] = 8'hFF;
          chk("hit", 32'(hit_out), 32'(e.hit));
          chk("hit_idx", 32'(hit_idx_out), 32'(e.idx));
          chk("evict_valid", 32'(evict_valid_out), 32'(e.ev));
          chk("evict_data", 32'(evict_data_out), 32'(e.evd));
          chk("entries", out & m, e.o & m);
          chk("out_valid", 32'(out_valid), 32'(e.v));
          chk("count", 32'(count_out), 32'(e.c));
        end
      end else begin
        chk("idle_resp_zero", {20'h0, hit_out, hit_idx_out, evict_valid_out, evict_data_out}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] key;
    logic [7:0] e [4];
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset_out", out, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_count", 32'(count_out), 32'h0);
    chk("reset_resp", 32'(resp_valid_out), 32'h0);
    @(posedge clk_in); #1;

    // Fill
    acc(8'd1, 1'b1, mk(0, 0, 0, 0, pk(1, 0, 0, 0), 4'h1, 3'd1));
    acc(8'd2, 1'b1, mk(0, 0, 0, 0, pk(2, 1, 0, 0), 4'h3, 3'd2));
    acc(8'd3, 1'b1, mk(0, 0, 0, 0, pk(3, 2, 1, 0), 4'h7, 3'd3));
    acc(8'd4, 1'b1, mk(0, 0, 0, 0, pk(4, 3, 2, 1), 4'hF, 3'd4));
    // Eviction, then mid-list hit
    acc(8'd5, 1'b1, mk(0, 0, 1, 8'd1, pk(5, 4, 3, 2), 4'hF, 3'd4));
    acc(8'd3, 1'b1, mk(1, 2, 0, 0, pk(3, 5, 4, 2), 4'hF, 3'd4));
    // Probe hit at tail, MRU hit, probe miss on a full tracker
    acc(8'd2, 1'b0, mk(1, 3, 0, 0, pk(3, 5, 4, 2), 4'hF, 3'd4));
    acc(8'd3, 1'b1, mk(1, 0, 0, 0, pk(3, 5, 4, 2), 4'hF, 3'd4));
    acc(8'd9, 1'b0, mk(0, 0, 0, 0, pk(3, 5, 4, 2), 4'hF, 3'd4));

    // Flush collides with an access; access is dropped
    flush_in = 1'b1; in_valid = 1'b1; in_update = 1'b1; data_in = 8'd7;
    @(posedge clk_in); #1;
    flush_in = 1'b0; in_valid = 1'b0; in_update = 1'b0;
    @(negedge clk_in);
    chk("flush_resp", 32'(resp_valid_out), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_count", 32'(count_out), 32'h0);
    @(posedge clk_in); #1;
    acc(8'd7, 1'b1, mk(0, 0, 0, 0, pk(7, 0, 0, 0), 4'h1, 3'd1));

    // Reset asserted between edges mid-stream
    acc(8'd1, 1'b1, mk(0, 0, 0, 0, pk(1, 7, 0, 0), 4'h3, 3'd2));
    acc(8'd2, 1'b1, mk(0, 0, 0, 0, pk(2, 1, 7, 0), 4'h7, 3'd3));
    in_valid = 1'b1; in_update = 1'b1; data_in = 8'd3;
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    in_valid = 1'b0; in_update = 1'b0;
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count_out), 32'h0);
    chk("rst_resp", {27'h0, resp_valid_out, hit_out, hit_idx_out, evict_valid_out}, 32'h0);
    chk("rst_evd", 32'(evict_data_out), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    acc(8'd2, 1'b1, mk(0, 0, 0, 0, pk(2, 0, 0, 0), 4'h1, 3'd1));

    // Soak: cycling keys 1..4 from state [2]
    for (int k = 0; k < 40; k++) begin
      key = 8'((k % 4) + 1);
      case (k)
        0: acc(key, 1'b1, mk(0, 0, 0, 0, pk(1, 2, 0, 0), 4'h3, 3'd2));
        1: acc(key, 1'b1, mk(1, 1, 0, 0, pk(2, 1, 0, 0), 4'h3, 3'd2));
        2: acc(key, 1'b1, mk(0, 0, 0, 0, pk(3, 2, 1, 0), 4'h7, 3'd3));
        3: acc(key, 1'b1, mk(0, 0, 0, 0, pk(4, 3, 2, 1), 4'hF, 3'd4));
        default: begin
          for (int i = 0; i < 4; i++) e[i] = 8'(((int'(key) - 1 - i + 8) % 4) + 1);
          acc(key, 1'b1, mk(1, 3, 0, 0, pk(e[0], e[1], e[2], e[3]), 4'hF, 3'd4));
        end
      endcase
    end

    repeat (2) @(negedge clk_in);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
